// File: rtl/check_node_min_sequencer.sv
// check_node_min_sequencer: two-pass min-sum magnitude search for one check node.
// Pass 1 reads every edge to find min1/min_idx and the sign parity; pass 2
// re-reads every edge except min_idx to find min2.
// Optional macro CNS_OFFSET_EN: min1/min2 are loaded as max(value-OFFSET, 0).
module check_node_min_sequencer #(
    parameter int unsigned DEG    = 6,
    parameter int unsigned MAG_W  = 5,
    parameter int unsigned IDX_W  = 6,
    parameter int          OFFSET = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             rd_en,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [MAG_W-1:0] rd_mag,
    input  logic             rd_sign,
    output logic             busy,
    output logic             done,
    output logic [MAG_W-1:0] min1,
    output logic [MAG_W-1:0] min2,
    output logic [IDX_W-1:0] min_idx,
    output logic             sign_par
);

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEG - 1);
    localparam logic [MAG_W-1:0] MAG_ONES  = '1;

    // Elaboration-time parameter sanity check
    if (DEG < 2 || DEG > 63 || (DEG - 1) >= (1 << IDX_W) || OFFSET < 0) begin : g_bad_param
        $error("check_node_min_sequencer: illegal DEG/IDX_W/OFFSET combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS1,
        S_DRAIN1,
        S_PASS2,
        S_DRAIN2,
        S_DONE
    } state_t;

    state_t           state_q, state_nxt;
    logic [IDX_W-1:0] addr_q, addr_nxt;
    logic [MAG_W-1:0] wmin1_q, wmin1_nxt;
    logic [MAG_W-1:0] wmin2_q, wmin2_nxt;
    logic [IDX_W-1:0] widx_q, widx_nxt;
    logic             par_q, par_nxt;
    logic             p1_vld_q, p2_vld_q;
    logic [IDX_W-1:0] tag_addr_q;
    logic [IDX_W-1:0] p2_last, p2_step;

`ifdef CNS_OFFSET_EN
    localparam logic [MAG_W-1:0] OFF_M = MAG_W'(OFFSET);

    // Saturating offset-min-sum correction applied when results are loaded
    function automatic logic [MAG_W-1:0] adj(input logic [MAG_W-1:0] v);
        return (v > OFF_M) ? (v - OFF_M) : '0;
    endfunction
`else
    // Raw minima pass straight through
    function automatic logic [MAG_W-1:0] adj(input logic [MAG_W-1:0] v);
        return v;
    endfunction
`endif

    assign rd_addr = addr_q;

    // Next-state, address generation and compare/absorb of the returning datum
    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        wmin1_nxt = wmin1_q;
        wmin2_nxt = wmin2_q;
        widx_nxt  = widx_q;
        par_nxt   = par_q;
        p2_last   = (widx_q == LAST_ADDR) ? (LAST_ADDR - IDX_W'(1)) : LAST_ADDR;
        p2_step   = addr_q + IDX_W'(1);

        // Pass-2 skip: step over min_idx so it is never read
        if (p2_step == widx_q) begin
            p2_step = addr_q + IDX_W'(2);
        end

        // Pass-1 datum: strict compare keeps the lowest index on ties
        if (p1_vld_q) begin
            par_nxt = par_q ^ rd_sign;
            if (rd_mag < wmin1_q) begin
                wmin1_nxt = rd_mag;
                widx_nxt  = tag_addr_q;
            end
        end

        // Pass-2 datum
        if (p2_vld_q && (rd_mag < wmin2_q)) begin
            wmin2_nxt = rd_mag;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_PASS1;
                    addr_nxt  = '0;
                    wmin1_nxt = MAG_ONES;
                    wmin2_nxt = MAG_ONES;
                    widx_nxt  = '0;
                    par_nxt   = 1'b0;
                end
            end
            S_PASS1: begin
                if (addr_q == LAST_ADDR) begin
                    state_nxt = S_DRAIN1;
                end else begin
                    addr_nxt = addr_q + IDX_W'(1);
                end
            end
            S_DRAIN1: begin
                state_nxt = S_PASS2;
                addr_nxt  = (widx_nxt == '0) ? IDX_W'(1) : '0;
            end
            S_PASS2: begin
                if (addr_q == p2_last) begin
                    state_nxt = S_DRAIN2;
                end else begin
                    addr_nxt = p2_step;
                end
            end
            S_DRAIN2: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, working registers, read tagging and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wmin1_q    <= MAG_ONES;
            wmin2_q    <= MAG_ONES;
            widx_q     <= '0;
            par_q      <= 1'b0;
            p1_vld_q   <= 1'b0;
            p2_vld_q   <= 1'b0;
            tag_addr_q <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            min1       <= '0;
            min2       <= '0;
            min_idx    <= '0;
            sign_par   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            addr_q     <= addr_nxt;
            wmin1_q    <= wmin1_nxt;
            wmin2_q    <= wmin2_nxt;
            widx_q     <= widx_nxt;
            par_q      <= par_nxt;
            p1_vld_q   <= (state_q == S_PASS1);
            p2_vld_q   <= (state_q == S_PASS2);
            tag_addr_q <= addr_q;
            rd_en      <= (state_nxt == S_PASS1) || (state_nxt == S_PASS2);
            busy       <= (state_nxt != S_IDLE);
            done       <= (state_nxt == S_DONE);
            if (state_q == S_DRAIN2) begin
                min1     <= adj(wmin1_nxt);
                min2     <= adj(wmin2_nxt);
                min_idx  <= widx_nxt;
                sign_par <= par_nxt;
            end
        end
    end

endmodule

// File: tb/tb_check_node_min_sequencer.sv
// Bench for check_node_min_sequencer: edge RAM responder plus a reference
// model built from plain min/xor over the stored edge vector.
module tb_check_node_min_sequencer;

    localparam int unsigned DEG    = 6;
    localparam int unsigned MAG_W  = 5;
    localparam int unsigned IDX_W  = 6;
    localparam int          OFFSET = 1;
    localparam int          BOUND  = 200;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [MAG_W-1:0] rd_mag = '0;
    logic             rd_sign = 1'b0;
    logic             busy, done, sign_par;
    logic [MAG_W-1:0] min1, min2;
    logic [IDX_W-1:0] min_idx;

    int checks = 0;
    int errors = 0;

    logic [MAG_W-1:0] mem [DEG];
    logic             sgn [DEG];
    int               addr_log [$];

    check_node_min_sequencer #(
        .DEG(DEG), .MAG_W(MAG_W), .IDX_W(IDX_W), .OFFSET(OFFSET)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_mag(rd_mag), .rd_sign(rd_sign),
        .busy(busy), .done(done), .min1(min1), .min2(min2),
        .min_idx(min_idx), .sign_par(sign_par)
    );

    always #5 clk = ~clk;

    // Edge RAM: data for a read issued in one cycle appears in the next; idle cycles carry junk
    logic             cap;
    logic [IDX_W-1:0] caddr;
    always begin
        @(negedge clk);
        cap   = rd_en;
        caddr = rd_addr;
        @(posedge clk);
        #1;
        if (cap) begin
            if (int'(caddr) < DEG) begin
                rd_mag  = mem[int'(caddr)];
                rd_sign = sgn[int'(caddr)];
            end else begin
                rd_mag  = '0;
                rd_sign = 1'b0;
            end
            addr_log.push_back(int'(caddr));
        end else begin
            rd_mag  = MAG_W'($urandom);
            rd_sign = 1'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int offs(input int v);
`ifdef CNS_OFFSET_EN
        return (v > OFFSET) ? v - OFFSET : 0;
`else
        return v;
`endif
    endfunction

    // Reference: min1 is the smallest value, min_idx its first position,
    // min2 the smallest of the remaining entries, parity the xor of all signs.
    task automatic model(output int e1, output int e2, output int ei, output int ep);
        int vals [$];
        for (int i = 0; i < DEG; i++) vals.push_back(int'(mem[i]));
        e1 = 1 << MAG_W;
        foreach (vals[i]) if (vals[i] < e1) e1 = vals[i];
        ei = -1;
        foreach (vals[i]) if (ei < 0 && vals[i] == e1) ei = i;
        vals.delete(ei);
        e2 = 1 << MAG_W;
        foreach (vals[i]) if (vals[i] < e2) e2 = vals[i];
        ep = 0;
        for (int i = 0; i < DEG; i++) ep = ep ^ int'(sgn[i]);
        e1 = offs(e1);
        e2 = offs(e2);
    endtask

    // One full search from a negedge; extra=1 adds stray start pulses in PASS1 and in DONE
    task automatic run_search(input string tag, input bit extra);
        int e1, e2, ei, ep, cyc, late_done, late_busy;
        bit done_seen, busy_ok, hold_ok, seq_ok;
        logic [MAG_W-1:0] p1, p2;
        logic [IDX_W-1:0] pi;
        logic             pp;
        int exp_addr [$];

        model(e1, e2, ei, ep);
        p1 = min1; p2 = min2; pi = min_idx; pp = sign_par;
        addr_log.delete();
        done_seen = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1; cyc = 0;
        start = 1'b1;
        while (!done_seen && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (extra && cyc == 3) start = 1'b1;
            if (extra && cyc == 4) start = 1'b0;
            if (done) begin
                done_seen = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (min1 !== p1 || min2 !== p2 || min_idx !== pi || sign_par !== pp) hold_ok = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(done_seen ? cyc : 9999), 32'(2 * DEG + 2));
        check({tag, " busy_during"}, 32'(busy_ok), 32'd1);
        check({tag, " results_hold"}, 32'(hold_ok), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd1);
        check({tag, " rd_en_at_done"}, 32'(rd_en), 32'd0);
        check({tag, " min1"}, 32'(min1), 32'(e1));
        check({tag, " min2"}, 32'(min2), 32'(e2));
        check({tag, " min_idx"}, 32'(min_idx), 32'(ei));
        check({tag, " sign_par"}, 32'(sign_par), 32'(ep));
        if (extra) start = 1'b1;
        late_done = 0; late_busy = 0;
        for (int k = 1; k <= 2 * DEG + 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done) late_done++;
            if (busy) late_busy++;
        end
        check({tag, " single_done"}, 32'(late_done), 32'd0);
        check({tag, " idle_after"}, 32'(late_busy), 32'd0);
        for (int i = 0; i < DEG; i++) exp_addr.push_back(i);
        for (int i = 0; i < DEG; i++) if (i != ei) exp_addr.push_back(i);
        seq_ok = (addr_log.size() == exp_addr.size());
        if (seq_ok) foreach (exp_addr[i]) if (addr_log[i] != exp_addr[i]) seq_ok = 1'b0;
        check({tag, " addr_count"}, 32'(addr_log.size()), 32'(exp_addr.size()));
        check({tag, " addr_seq"}, 32'(seq_ok), 32'd1);
    endtask

    initial begin
        int rst_cyc, bad_done, bad_rden;

        // Reset state
        #12;
        check("reset rd_en", 32'(rd_en), 32'd0);
        check("reset rd_addr", 32'(rd_addr), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset min1", 32'(min1), 32'd0);
        check("reset min2", 32'(min2), 32'd0);
        check("reset min_idx", 32'(min_idx), 32'd0);
        check("reset sign_par", 32'(sign_par), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Tie between index 1 and 3
        mem = '{5'd7, 5'd3, 5'd9, 5'd3, 5'd12, 5'd5};
        sgn = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_search("vec_tie", 1'b0);

        // Minimum at index 0
        mem = '{5'd2, 5'd8, 5'd6, 5'd4, 5'd9, 5'd10};
        sgn = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        run_search("vec_first", 1'b0);

        // Minimum at last index
        mem = '{5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd1};
        sgn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        run_search("vec_last", 1'b0);

        // Zero magnitudes (saturation case under the offset build)
        mem = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd4};
        sgn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_search("vec_zero", 1'b0);

        // Stray start pulses in PASS1 and in the DONE cycle
        mem = '{5'd31, 5'd17, 5'd30, 5'd16, 5'd18, 5'd31};
        sgn = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_search("extra_start", 1'b1);

        // Reset pulse mid-PASS2 aborts the search
        mem = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd4};
        sgn = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        addr_log.delete();
        start = 1'b1;
        rst_cyc = 0;
        while (addr_log.size() < DEG + 2 && rst_cyc < BOUND) begin
            @(negedge clk);
            rst_cyc++;
            start = 1'b0;
        end
        check("abort reached_pass2", 32'(addr_log.size() >= DEG + 2), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort rd_en", 32'(rd_en), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort min1", 32'(min1), 32'd0);
        check("abort min_idx", 32'(min_idx), 32'd0);
        check("abort sign_par", 32'(sign_par), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bad_done = 0; bad_rden = 0;
        for (int k = 0; k < 2 * DEG + 4; k++) begin
            @(negedge clk);
            if (done) bad_done++;
            if (rd_en) bad_rden++;
        end
        check("abort no_done", 32'(bad_done), 32'd0);
        check("abort no_reads", 32'(bad_rden), 32'd0);
        run_search("after_abort", 1'b0);

        // Randomized vectors; odd iterations use a tiny range to force ties
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < DEG; i++) begin
                mem[i] = MAG_W'((n % 2 == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
                sgn[i] = 1'($urandom);
            end
            run_search($sformatf("rand%0d", n), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/check_node_min_sequencer.md
Name: check_node_min_sequencer

Overview:
- Sequences the two-pass min-sum magnitude search for one check node in the BP decoder.
- Pass 1 reads all DEG incoming variable-to-check magnitudes from the edge message RAM, finding min1, min_idx and the sign parity.
- Pass 2 re-reads every edge except min_idx to find min2. The skip is done in its own address generator.
- Sits between the check-node scheduler (start/done) and the edge RAM read port. Its results feed the check-to-variable message generator.

Parameters:
- DEG, 6, check node degree; legal range 2..63.
- MAG_W, 5, magnitude width.
- IDX_W, 6, edge index / address width.
- OFFSET, 1, offset-min-sum correction; used only when CNS_OFFSET_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low; clears all state.
- start  in  1  begin a search; sampled only in IDLE.
- rd_en  out  1  edge RAM read strobe.
- rd_addr  out  IDX_W  edge index being read.
- rd_mag  in  MAG_W  magnitude; valid exactly 1 cycle after its rd_en.
- rd_sign  in  1  sign bit; same timing as rd_mag.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high, inclusive.
- done  out  1  one-cycle pulse; result registers are valid from this cycle.
- min1  out  MAG_W  smallest magnitude.
- min2  out  MAG_W  second smallest magnitude, excluding index min_idx.
- min_idx  out  IDX_W  index of min1.
- sign_par  out  1  XOR of all DEG sign bits.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; working min registers all-ones.
- FSM states: IDLE, PASS1, DRAIN1, PASS2, DRAIN2, DONE.
- IDLE -> PASS1 when start=1.
  - On that edge: working min1/min2 <= all-ones, working idx <= 0, parity <= 0, address counter <= 0.
- PASS1:
  - Issues rd_en=1 with rd_addr = 0..DEG-1, one address per cycle.
  - Goes to DRAIN1 after address DEG-1 is issued.
- Compare rule (both passes):
  - Applied in the cycle after each read; data tagged with the address registered alongside it.
  - Update only when rd_mag < current minimum (strict). On ties the lowest index wins.
- Pass 1 parity: XOR-accumulate rd_sign for every pass-1 read.
- DRAIN1:
  - rd_en=0; absorbs the last pass-1 datum.
  - Loads the pass-2 start address: 1 if the new min_idx==0, else 0. Then goes to PASS2.
- PASS2 addressing:
  - Issues DEG-1 reads.
  - Next address = addr+1, and +1 again if that value equals min_idx.
  - min_idx itself is never read.
  - If min_idx==DEG-1, the last address read is DEG-2.
  - Goes to DRAIN2 after the (DEG-1)th read.
- DRAIN2: absorbs the final datum; rd_en=0.
- DONE:
  - done=1 for one cycle.
  - min1, min2, min_idx and sign_par load from the working registers.
  - Returns to IDLE.
- Latency: if start is sampled at edge T, done is high in the cycle after edge T+2*DEG+1, i.e. 2*DEG+2 cycles after start.
- rd_en is never high in IDLE, DRAIN or DONE states.
- Result outputs hold their values between done pulses, so they stay stable during the next search.
- start while not in IDLE is ignored; there is no queueing.
- If start is high in the DONE cycle, it is ignored.
- A reset_n assertion mid-search aborts immediately: rd_en drops asynchronously and no done is issued.
- Addresses never exceed DEG-1, and the counter never wraps.

Optional Feature:
- Macro: CNS_OFFSET_EN.
- Defined:
  - min1 and min2 load as max(value-OFFSET, 0). Saturating; never wraps.
  - min_idx and sign_par are unaffected.
- Undefined:
  - Raw minima are output; the OFFSET parameter is unused.
  - No subtractor is instantiated.

Test Plan:
- DEG=6, mags [7,3,9,3,12,5], signs [1,0,1,1,0,0]:
  - Expect min1=3, min_idx=1, min2=3 (index 3), sign_par=1.
  - Pass-2 addresses 0,2,3,4,5.
  - done exactly 14 cycles after start.
- mags [2,8,6,4,9,10] (min at index 0):
  - Pass-2 addresses 1,2,3,4,5.
  - Expect min1=2, min_idx=0, min2=4.
- mags [9,8,7,6,5,1] (min at last index):
  - Pass-2 addresses 0..4; no read of address 5.
  - Expect min1=1, min_idx=5, min2=5.
- Second start pulse during PASS1 and another in the DONE cycle:
  - Only one search runs and one done pulse appears.
  - Previous results hold until that done.
- reset_n low for 1 cycle mid-PASS2:
  - rd_en=0 and all outputs 0 immediately; no done.
  - A new start afterwards gives correct results.
- CNS_OFFSET_EN defined, OFFSET=1:
  - First vector gives min1=2, min2=2.
  - mags [0,0,4,4,4,4] give min1=0, min2=0 (saturation), min_idx=0.
